// File: rtl/ascii_stream_decoder_if.sv
// ---------------------------------------------------------------------------
// ascii_stream_decoder_if
//   Handshake bundle between a position-code source, the decoder and a
//   character sink.
//   in_valid/in_ready/in_pos      : code-word input channel (valid/ready)
//   out_valid/out_ready           : decoded character channel (valid/ready)
//   out_ascii/out_eos             : FIFO head character and end-of-sentence flag
//   master : the environment (drives codes, accepts characters)
//   slave  : the decoder
// ---------------------------------------------------------------------------
interface ascii_stream_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_pos;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] out_ascii;
  logic       out_eos;

  modport master (
    output in_valid, in_pos, out_ready,
    input  in_ready, out_valid, out_ascii, out_eos
  );

  modport slave (
    input  in_valid, in_pos, out_ready,
    output in_ready, out_valid, out_ascii, out_eos
  );
endinterface

// File: rtl/ascii_stream_decoder.sv
// ---------------------------------------------------------------------------
// ascii_stream_decoder
//   Turns a stream of 5-bit character-position codes into 7-bit ASCII,
//   capitalising the first letter of each sentence, and queues the result in
//   a small FIFO. Illegal codes (27, 28) are dropped and flagged.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of the code-in / character-out handshakes
//   err      : one-cycle pulse after an illegal code is accepted
//   err_cnt  : saturating count of illegal codes
//   char_cnt : saturating count of characters written to the FIFO
// ---------------------------------------------------------------------------
module ascii_stream_decoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8,
  parameter bit CAPS  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ascii_stream_decoder_if.slave bus,
  output logic                  err,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      char_cnt
);

  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic {SOS, MID} state_e;

  typedef struct packed {
    logic       eos;
    logic [6:0] ascii;
  } entry_t;

  state_e          state_q;
  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            err_q;
  logic [CNT_W-1:0] err_cnt_q, char_cnt_q;

  logic   accept, push, pop, full;
  logic   dec_legal, dec_letter;
  entry_t dec;

  assign full   = (count_q == FULL_CNT);
  assign accept = bus.in_valid & ~full;
  assign pop    = (count_q != '0) & bus.out_ready;
  assign push   = accept & dec_legal;

  // Code-to-character table; letters take the capital offset only at the
  // start of a sentence.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    dec        = '0;
    dec_legal  = 1'b1;
    dec_letter = 1'b0;
    case (bus.in_pos)
      5'd0:        dec.ascii = 7'd32;
      5'd27, 5'd28: dec_legal = 1'b0;
      5'd29:       dec.ascii = 7'd44;
      5'd30:       dec       = '{eos: 1'b1, ascii: 7'd46};
      5'd31:       dec       = '{eos: 1'b1, ascii: 7'd63};
      default: begin
        dec_letter = 1'b1;
        dec.ascii  = ((CAPS && state_q == SOS) ? 7'd64 : 7'd96) + {2'b00, bus.in_pos};
      end
    endcase
  end

  // Next head of the FIFO. The head is kept in its own register so the
  // output holds its last value once the FIFO drains. When the slot being
  // written this cycle becomes the head (empty FIFO, or the last entry is
  // popped), the incoming entry bypasses the memory.
  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(pop);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    head_d = head_q;
    if (count_d != '0) begin
      head_d = (push && wr_ptr_q == rd_ptr_d) ? dec : mem_q[rd_ptr_d];
    end
  end

  // NOTE: the storage array has no reset; its contents are only observed
  // through head_q after being written, so clearing it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q    <= SOS;
      head_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      char_cnt_q <= '0;
    end else begin
      head_q   <= head_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      err_q    <= accept & ~dec_legal;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (push && char_cnt_q != '1) char_cnt_q <= char_cnt_q + 1'b1;
      if (accept && !dec_legal && err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
      // Sentence tracking: terminators restart a sentence, the first letter
      // ends the capitalisation window; everything else leaves it alone.
      if (accept) begin
        if (dec_legal && dec.eos)            state_q <= SOS;
        else if (dec_letter && state_q == SOS) state_q <= MID;
      end
    end
  end

  assign bus.in_ready  = ~full;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_ascii = head_q.ascii;
  assign bus.out_eos   = head_q.eos;
  assign err           = err_q;
  assign err_cnt       = err_cnt_q;
  assign char_cnt      = char_cnt_q;

endmodule

// File: tb/tb_ascii_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_ascii_stream_decoder
//   Self-checking bench: a queue-based reference model runs alongside the
//   DUT every cycle, a table of decode vectors covers the character map and
//   sentence capitalisation, and hand-written sequences cover back-pressure,
//   steady-state streaming, counter saturation and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_ascii_stream_decoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam bit CAPS  = 1'b1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             err;
  logic [CNT_W-1:0] err_cnt, char_cnt;

  always #5 clk = ~clk;

  ascii_stream_decoder_if bus();

  ascii_stream_decoder #(.DEPTH(DEPTH), .CNT_W(CNT_W), .CAPS(CAPS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .err      (err),
    .err_cnt  (err_cnt),
    .char_cnt (char_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: bit 7 = eos, bits 6:0 = ascii.
  logic [7:0] m_q[$];
  logic [7:0] m_head;
  bit         m_sos;
  bit         m_err;
  int         m_chars, m_errs;
  logic [6:0] popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void ref_decode(input int pos, input bit sos,
                                     output bit legal, output logic [7:0] ent);
    legal = 1'b1;
    case (pos)
      0:       ent = 8'd32;
      27, 28:  begin legal = 1'b0; ent = 8'd0; end
      29:      ent = 8'd44;
      30:      ent = 8'h80 | 8'd46;
      31:      ent = 8'h80 | 8'd63;
      default: ent = 8'((CAPS && sos) ? 64 + pos : 96 + pos);
    endcase
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_head  = '0;
    m_sos   = 1'b1;
    m_err   = 1'b0;
    m_chars = 0;
    m_errs  = 0;
  endtask

  // One clock cycle: inputs are already driven; advance model and DUT,
  // then compare every output 1 time unit after the edge.
  task automatic tick(output bit acc);
    bit         pop, legal;
    logic [7:0] ent;
    int         pos;
    acc = bus.in_valid && (m_q.size() < DEPTH);
    pop = (m_q.size() > 0) && bus.out_ready;
    pos = int'(bus.in_pos);
    if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_ascii);
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    m_err = 1'b0;
    if (acc) begin
      ref_decode(pos, m_sos, legal, ent);
      if (legal) begin
        m_q.push_back(ent);
        if (m_chars < CMAX) m_chars++;
        if (pos >= 1 && pos <= 26) m_sos = 1'b0;
        if (ent[7]) m_sos = 1'b1;
      end else begin
        m_err = 1'b1;
        if (m_errs < CMAX) m_errs++;
      end
    end
    if (m_q.size() > 0) m_head = m_q[0];
    #1;
    check("out_valid", bus.out_valid, m_q.size() > 0);
    check("out_head",  {bus.out_eos, bus.out_ascii}, m_head);
    check("err",       err, m_err);
    check("err_cnt",   err_cnt, m_errs);
    check("char_cnt",  char_cnt, m_chars);
    check("in_ready",  bus.in_ready, m_q.size() < DEPTH);
  endtask

  task automatic send(input int pos);
    bit acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_pos   = 5'(pos);
    for (int k = 0; k < 20 && !acc; k++) tick(acc);
    check("send_accepted", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    bus.in_valid = 1'b0;
    for (int k = 0; k < n; k++) tick(acc);
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.in_pos    = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int pos;
    int ascii;
    bit eos;
    bit err;
    int chars;
  } vec_t;

  vec_t vecs[18];

  initial begin
    bit acc;
    int n_chars;

    vecs[0]  = '{8,  72,  0, 0, 1};
    vecs[1]  = '{9,  105, 0, 0, 2};
    vecs[2]  = '{0,  32,  0, 0, 3};
    vecs[3]  = '{20, 116, 0, 0, 4};
    vecs[4]  = '{30, 46,  1, 0, 5};
    vecs[5]  = '{31, 63,  1, 0, 6};
    vecs[6]  = '{1,  65,  0, 0, 7};
    vecs[7]  = '{0,  32,  0, 0, 8};
    vecs[8]  = '{1,  97,  0, 0, 9};
    vecs[9]  = '{29, 44,  0, 0, 10};
    vecs[10] = '{1,  97,  0, 0, 11};
    vecs[11] = '{30, 46,  1, 0, 12};
    vecs[12] = '{27, 0,   0, 1, 12};
    vecs[13] = '{28, 0,   0, 1, 12};
    vecs[14] = '{2,  66,  0, 0, 13};
    vecs[15] = '{26, 122, 0, 0, 14};
    vecs[16] = '{31, 63,  1, 0, 15};
    vecs[17] = '{0,  32,  0, 0, 16};

    // Reset state
    do_reset();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ascii", bus.out_ascii, 0);
    check("rst_out_eos",   bus.out_eos, 0);
    check("rst_err",       err, 0);
    check("rst_err_cnt",   err_cnt, 0);
    check("rst_char_cnt",  char_cnt, 0);
    check("rst_in_ready",  bus.in_ready, 1);

    // Decode table with an always-ready sink: each character appears the
    // cycle after it is accepted.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      send(vecs[i].pos);
      check("vec_out_valid", bus.out_valid, !vecs[i].err);
      if (!vecs[i].err) begin
        check("vec_ascii", bus.out_ascii, vecs[i].ascii);
        check("vec_eos",   bus.out_eos, vecs[i].eos);
      end
      check("vec_err",   err, vecs[i].err);
      check("vec_chars", char_cnt, vecs[i].chars);
    end
    check("table_err_cnt", err_cnt, 2);
    idle(2);

    // Back-pressure: four entries fill the FIFO, the fifth waits until one
    // pop has happened and is accepted on the following cycle.
    popped.delete();
    bus.out_ready = 1'b0;
    send(3); send(15); send(4); send(5);
    check("full_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_pos   = 5'd19;
    tick(acc);
    check("fifth_waits", acc, 0);
    bus.out_ready = 1'b1;
    tick(acc);
    check("pop_while_full_no_accept", acc, 0);
    check("ready_after_pop", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    tick(acc);
    check("fifth_accepted", acc, 1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    idle(6);
    check("order_len", popped.size(), 5);
    if (popped.size() == 5) begin
      check("order_0", popped[0], 67);
      check("order_1", popped[1], 111);
      check("order_2", popped[2], 100);
      check("order_3", popped[3], 101);
      check("order_4", popped[4], 115);
    end

    // Steady streaming with the FIFO half full: occupancy must not move.
    bus.out_ready = 1'b0;
    send(7); send(8);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_pos = 5'($urandom_range(0, 26));
      check("hf_out_valid", bus.out_valid, 1);
      check("hf_in_ready",  bus.in_ready, 1);
      tick(acc);
    end
    idle(4);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 1) != 0);
      bus.in_pos    = 5'($urandom_range(0, 31));
      tick(acc);
    end
    bus.out_ready = 1'b1;
    idle(6);

    // Counter saturation.
    bus.in_valid = 1'b1;
    bus.in_pos   = 5'd0;
    for (int i = 0; i < 260; i++) tick(acc);
    bus.in_pos = 5'd27;
    for (int i = 0; i < 260; i++) tick(acc);
    bus.in_valid = 1'b0;
    check("char_cnt_sat", char_cnt, CMAX);
    check("err_cnt_sat",  err_cnt, CMAX);
    idle(2);

    // Mid-stream reset with three entries queued and one error counted.
    do_reset();
    send(27);
    send(12); send(13); send(14);
    check("pre_rst_err_cnt",  err_cnt, 1);
    n_chars = int'(char_cnt);
    check("pre_rst_char_cnt", n_chars, 3);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_err_cnt",   err_cnt, 0);
    check("mid_rst_char_cnt",  char_cnt, 0);
    check("mid_rst_in_ready",  bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(5);
    check("post_rst_caps", bus.out_ascii, 69);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
